neureka_streamer_sched: RTL and testbench
=========================================

# neureka_streamer_sched

Command-driven sequencer for the NEUREKA streamer. It accepts one load/store command at a time from the main controller FSM and drives the streamer's load/store mux select, load-source select and weight-memory select. It emits the clear and start pulses to the sources, sink and TCDM FIFO, waits for completion, and reports per-command cycle counts. It sits between the NEUREKA control FSM and the streamer control channel, so that mux selects never change while TCDM traffic is in flight.

## Interface
Parameters:
- CNT_W, 16, width of the per-command cycle counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; identical effect to rst_i.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready; high only in IDLE.
- cmd_kind_i  in  3  command kind: 0 FEAT, 1 WEIGHT, 2 FEAT_WEIGHT, 3 NORM, 4 STREAMIN, 5 STORE; 6 and 7 are illegal.
- cmd_wmem_i  in  1  WEIGHT uses the dedicated weight-memory source; forced to 1 for FEAT_WEIGHT and to 0 for all other kinds.
- ld_st_mux_sel_o  out  1  0 = load, 1 = store.
- ld_which_mux_sel_o  out  3  load kind (cmd_kind encoding 0..4).
- wmem_sel_o  out  1  weight-memory select.
- clear_source_o, clear_sink_o, clear_fifo_o  out  1 each  one-cycle clear pulses.
- req_start_o  out  1  one-cycle start pulse to the active source(s) or sink.
- source_done_i, wmem_done_i, sink_done_i  in  1 each  completion pulses.
- tcdm_fifo_empty_i  in  1  TCDM FIFO empty flag.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse when a command completes.
- err_o  out  1  one-cycle pulse when an illegal kind is accepted.
- cycles_o  out  CNT_W  cycle count of the last completed command; saturates at all-ones.

## Operation
- States: IDLE, DRAIN, CLEAR, START, RUN. All outputs are registered.
- IDLE: cmd_ready_o=1. On accept (cmd_valid_i & cmd_ready_o), latch kind and wmem, then take exactly one of:
  - Illegal kind: pulse err_o next cycle, stay IDLE, change no selects.
  - Direction (load/store) differs from ld_st_mux_sel_o: go to DRAIN.
  - Same direction but kind/wmem differs from the last executed command, or no command executed since reset: go to CLEAR.
  - Otherwise: go to START.
- DRAIN: hold all selects. Leave for CLEAR in the cycle tcdm_fifo_empty_i=1 (checked in that same cycle).
- CLEAR: one cycle.
  - Selects take their new values on the edge entering CLEAR.
  - Pulse clear_source_o on loads, clear_sink_o on stores.
  - Pulse clear_fifo_o only when entered from DRAIN.
  - Next state START.
- START: one cycle, req_start_o=1; cycle counter loads 1. Next state RUN.
- RUN: counter increments each cycle, saturating.
  - Required done set: FEAT/NORM/STREAMIN and WEIGHT with wmem=0 need source; WEIGHT with wmem=1 needs wmem; FEAT_WEIGHT needs source and wmem; STORE needs sink.
  - Done pulses are captured sticky from START onward; stickies clear in IDLE.
  - Leave for IDLE in the cycle all required dones are seen (sticky or live). That cycle's count is copied to cycles_o.
- done_o pulses in the first IDLE cycle after RUN. A new command may be accepted in that same cycle.
- Reset/clear at any point: state IDLE, ld_st_mux_sel_o=0, ld_which_mux_sel_o=0, wmem_sel_o=0, all pulses 0, busy_o=0, cycles_o=0, stickies 0, "last command" invalid. An aborted command produces no done_o.

## Timing
- Accept at cycle t:
  - Same command as the previous one: req_start_o at t+1.
  - Kind change, same direction: clear at t+1, start at t+2.
  - Direction change: DRAIN from t+1 until the FIFO is empty; CLEAR in the cycle after empty is seen; START one cycle later.
- Minimum command length is 3 cycles (accept, START, RUN with live done), plus 1 cycle for done_o, which overlaps the next accept.
- Selects are constant from CLEAR through RUN and never change in DRAIN, START or RUN.
- A done pulse arriving in IDLE, DRAIN or CLEAR is ignored. One arriving in the START cycle counts.

## Test plan
- After reset, issue FEAT.
  - Clear_source at t+1, req_start at t+2, ld_which=0.
  - source_done 5 cycles after start: done_o pulses, cycles_o=6.
- Issue a second FEAT back-to-back, accepted in the done_o cycle: req_start at t+1, no clear pulses.
- FEAT then STORE with tcdm_fifo_empty_i held low for 4 cycles.
  - 4 DRAIN cycles with ld_st_mux_sel_o still 0.
  - Then CLEAR with clear_fifo_o=1, clear_sink_o=1, ld_st_mux_sel_o=1.
  - Then START.
- FEAT_WEIGHT with wmem_done at RUN cycle 2 and source_done at cycle 7: completes only at cycle 7, wmem_sel_o=1 throughout.
- Kind 7 accepted: err_o for one cycle, selects unchanged, busy_o stays 0.
- Assert rst_i during RUN: all outputs return to reset values next cycle; no done_o; the next FEAT goes through CLEAR.

Source files
------------

// File: rtl/neureka_streamer_sched.sv
// neureka_streamer_sched: sequences streamer mux selects, clear/start pulses and completion for one load/store command at a time
module neureka_streamer_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_kind_i,
  input  logic             cmd_wmem_i,
  output logic             ld_st_mux_sel_o,
  output logic [2:0]       ld_which_mux_sel_o,
  output logic             wmem_sel_o,
  output logic             clear_source_o,
  output logic             clear_sink_o,
  output logic             clear_fifo_o,
  output logic             req_start_o,
  input  logic             source_done_i,
  input  logic             wmem_done_i,
  input  logic             sink_done_i,
  input  logic             tcdm_fifo_empty_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cycles_o
);
  typedef enum logic [2:0] {IDLE, DRAIN, CLEAR, START, RUN} state_t;
  state_t state, state_d;
  logic flush, accept, illegal, in_wmem, in_store, same_cmd;
  logic [2:0] kind_q, last_kind, nxt_kind;
  logic wmem_q, last_wmem, last_vld, nxt_wmem;
  logic src_s, wmem_s, sink_s, need_src, need_wmem, need_sink, all_done;
  logic [CNT_W-1:0] cnt;
  assign flush = rst_i | clear_i;
  assign accept = cmd_valid_i & cmd_ready_o;
  assign illegal = &cmd_kind_i[2:1];
  assign in_wmem = cmd_kind_i == 3'd2 || (cmd_kind_i == 3'd1 && cmd_wmem_i);
  assign in_store = cmd_kind_i == 3'd5;
  assign same_cmd = last_vld && last_kind == cmd_kind_i && last_wmem == in_wmem;
  assign nxt_kind = accept ? cmd_kind_i : kind_q;
  assign nxt_wmem = accept ? in_wmem : wmem_q;
  assign need_sink = kind_q == 3'd5;
  assign need_wmem = wmem_q;
  assign need_src = !need_sink && !(kind_q == 3'd1 && wmem_q);
  // a done counts if it was captured earlier or is arriving right now
  assign all_done = (!need_src || src_s || source_done_i) &&
                    (!need_wmem || wmem_s || wmem_done_i) &&
                    (!need_sink || sink_s || sink_done_i);
  always_ff @(posedge clk_i)
    state <= flush ? IDLE : state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && !illegal) state_d = in_store != ld_st_mux_sel_o ? DRAIN : same_cmd ? START : CLEAR;
      DRAIN:   if (tcdm_fifo_empty_i) state_d = CLEAR;
      CLEAR:   state_d = START;
      START:   state_d = RUN;
      RUN:     if (all_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (flush) begin
      cmd_ready_o        <= 1'b1;
      busy_o             <= 1'b0;
      ld_st_mux_sel_o    <= 1'b0;
      ld_which_mux_sel_o <= 3'd0;
      wmem_sel_o         <= 1'b0;
      clear_source_o     <= 1'b0;
      clear_sink_o       <= 1'b0;
      clear_fifo_o       <= 1'b0;
      req_start_o        <= 1'b0;
      done_o             <= 1'b0;
      err_o              <= 1'b0;
      cycles_o           <= '0;
      cnt                <= '0;
      kind_q             <= 3'd0;
      wmem_q             <= 1'b0;
      last_vld           <= 1'b0;
      last_kind          <= 3'd0;
      last_wmem          <= 1'b0;
      src_s              <= 1'b0;
      wmem_s             <= 1'b0;
      sink_s             <= 1'b0;
    end else begin
      cmd_ready_o        <= state_d == IDLE;
      busy_o             <= state_d != IDLE;
      ld_st_mux_sel_o    <= state_d == CLEAR ? nxt_kind == 3'd5 : ld_st_mux_sel_o;
      ld_which_mux_sel_o <= state_d == CLEAR && nxt_kind != 3'd5 ? nxt_kind : ld_which_mux_sel_o;
      wmem_sel_o         <= state_d == CLEAR ? nxt_wmem : wmem_sel_o;
      clear_source_o     <= state_d == CLEAR && nxt_kind != 3'd5;
      clear_sink_o       <= state_d == CLEAR && nxt_kind == 3'd5;
      clear_fifo_o       <= state_d == CLEAR && state == DRAIN;
      req_start_o        <= state_d == START;
      done_o             <= state == RUN && all_done;
      err_o              <= accept && illegal;
      cycles_o           <= state == RUN && all_done ? cnt : cycles_o;
      cnt                <= state_d == START ? CNT_W'(1) :
                            state == START || state == RUN ? (&cnt ? cnt : cnt + CNT_W'(1)) : cnt;
      kind_q             <= nxt_kind;
      wmem_q             <= nxt_wmem;
      last_vld           <= last_vld || (accept && !illegal);
      last_kind          <= accept && !illegal ? cmd_kind_i : last_kind;
      last_wmem          <= accept && !illegal ? in_wmem : last_wmem;
      src_s              <= state == IDLE ? 1'b0 : state == START || state == RUN ? src_s | source_done_i : src_s;
      wmem_s             <= state == IDLE ? 1'b0 : state == START || state == RUN ? wmem_s | wmem_done_i : wmem_s;
      sink_s             <= state == IDLE ? 1'b0 : state == START || state == RUN ? sink_s | sink_done_i : sink_s;
    end
  end
endmodule

// File: tb/tb_neureka_streamer_sched.sv
// tb_neureka_streamer_sched: random and directed commands checked cycle by cycle against a timeline model
module tb_neureka_streamer_sched;
  logic clk = 1'b0;
  logic rst_i, clear_i, cmd_valid_i, cmd_wmem_i, source_done_i, wmem_done_i, sink_done_i, tcdm_fifo_empty_i;
  logic [2:0] cmd_kind_i;
  logic cmd_ready_o, ld_st_mux_sel_o, wmem_sel_o, clear_source_o, clear_sink_o, clear_fifo_o;
  logic req_start_o, busy_o, done_o, err_o;
  logic [2:0] ld_which_mux_sel_o;
  logic [3:0] cycles_o;
  int tests = 0, fails = 0;
  logic m_ls, m_wm, m_lv, m_lwm;
  logic [2:0] m_wh, m_lk;
  int m_cyc;

  neureka_streamer_sched #(.CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_kind_i(cmd_kind_i), .cmd_wmem_i(cmd_wmem_i),
    .ld_st_mux_sel_o(ld_st_mux_sel_o), .ld_which_mux_sel_o(ld_which_mux_sel_o), .wmem_sel_o(wmem_sel_o),
    .clear_source_o(clear_source_o), .clear_sink_o(clear_sink_o), .clear_fifo_o(clear_fifo_o),
    .req_start_o(req_start_o), .source_done_i(source_done_i), .wmem_done_i(wmem_done_i),
    .sink_done_i(sink_done_i), .tcdm_fifo_empty_i(tcdm_fifo_empty_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ls = 1'b0; m_wh = 3'd0; m_wm = 1'b0; m_lv = 1'b0; m_lk = 3'd0; m_lwm = 1'b0; m_cyc = 0;
  endtask

  // d: FIFO-empty delay from accept; ds/dw/dk: done offsets from START; abort_rel: reset offset from START (-1 none)
  task automatic run_cmd(input int kind, input bit wm, input int d, input int ds, input int dw, input int dk,
                         input int abort_rel, input bit use_clr);
    bit store, illegal, ew, ns, dir, same, past, rst_row;
    int n, cc, s, mx, e, ab, last, cyc, exp_cyc;
    logic [12:0] exp, got;
    logic [2:0] nwh;
    store = kind == 5;
    illegal = kind > 5;
    ew = kind == 2 || (kind == 1 && wm);
    ns = !illegal && !store && !(kind == 1 && wm);
    dir = !illegal && store != m_ls;
    same = !illegal && !dir && m_lv && m_lk == 3'(kind) && m_lwm == ew;
    n = d < 1 ? 1 : d;
    cc = (illegal || same) ? -1 : dir ? n + 1 : 1;
    s = same ? 1 : cc + 1;
    mx = 0;
    if (ns && ds > mx) mx = ds;
    if (ew && dw > mx) mx = dw;
    if (store && dk > mx) mx = dk;
    e = s + (mx < 1 ? 1 : mx);
    ab = (illegal || abort_rel < 0) ? -1 : s + (abort_rel > e - s ? e - s : abort_rel);
    last = illegal ? 1 : ab >= 0 ? ab + 1 : e + 1;
    cyc = e - s + 1 > 15 ? 15 : e - s + 1;
    nwh = store ? m_wh : 3'(kind);
    chk($sformatf("k%0d ready_at_accept", kind), 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_kind_i = 3'(kind); cmd_wmem_i = wm; tcdm_fifo_empty_i = d == 0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      past = cc >= 0 && c >= cc;
      rst_row = ab >= 0 && c == ab + 1;
      if (rst_row) exp = {1'b1, 12'd0};
      else if (illegal) exp = {1'b1, 1'b0, 4'd0, 1'b1, 1'b0, m_ls, m_wh, m_wm};
      else exp = {c > e, c <= e, c == s, c == cc && !store, c == cc && store, c == cc && dir, 1'b0, c == e + 1,
                  past ? store : m_ls, past ? nwh : m_wh, past ? ew : m_wm};
      got = {cmd_ready_o, busy_o, req_start_o, clear_source_o, clear_sink_o, clear_fifo_o, err_o, done_o,
             ld_st_mux_sel_o, ld_which_mux_sel_o, wmem_sel_o};
      chk($sformatf("k%0d c%0d status", kind, c), 32'(got), 32'(exp));
      exp_cyc = rst_row ? 0 : (illegal || c <= e) ? m_cyc : cyc;
      chk($sformatf("k%0d c%0d cycles", kind, c), 32'(cycles_o), 32'(exp_cyc));
      cmd_valid_i = 1'b0;
      tcdm_fifo_empty_i = c >= d;
      source_done_i = (ns && c == s + ds) || c == cc;
      wmem_done_i = (ew && c == s + dw) || c == cc;
      sink_done_i = (store && c == s + dk) || c == cc;
      rst_i = ab >= 0 && c == ab && !use_clr;
      clear_i = ab >= 0 && c == ab && use_clr;
    end
    if (ab >= 0) model_reset();
    else if (!illegal) begin
      if (cc >= 0) begin m_ls = store; m_wh = nwh; m_wm = ew; end
      m_lv = 1'b1; m_lk = 3'(kind); m_lwm = ew; m_cyc = cyc;
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; cmd_valid_i = 1'b0; cmd_kind_i = 3'd0; cmd_wmem_i = 1'b0;
    source_done_i = 1'b0; wmem_done_i = 1'b0; sink_done_i = 1'b0; tcdm_fifo_empty_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset status", 32'({cmd_ready_o, busy_o, req_start_o, clear_source_o, clear_sink_o, clear_fifo_o, err_o,
        done_o, ld_st_mux_sel_o, ld_which_mux_sel_o, wmem_sel_o}), 32'({1'b1, 12'd0}));
    chk("reset cycles", 32'(cycles_o), 32'd0);
    rst_i = 1'b0;
    run_cmd(0, 0, 1, 5, 0, 0, -1, 0);
    run_cmd(0, 0, 1, 2, 0, 0, -1, 0);
    run_cmd(5, 0, 4, 0, 0, 3, -1, 0);
    run_cmd(2, 0, 2, 7, 2, 0, -1, 0);
    run_cmd(7, 0, 0, 0, 0, 0, -1, 0);
    run_cmd(6, 1, 0, 0, 0, 0, -1, 0);
    run_cmd(1, 1, 0, 0, 3, 0, -1, 0);
    run_cmd(3, 0, 0, 20, 0, 0, -1, 0);
    run_cmd(0, 0, 1, 100, 0, 0, 2, 0);
    run_cmd(0, 0, 1, 4, 0, 0, -1, 0);
    run_cmd(4, 0, 1, 100, 0, 0, 1, 1);
    run_cmd(4, 0, 1, 0, 0, 0, -1, 0);
    for (int i = 0; i < 60; i++)
      run_cmd(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
              $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 3)) : -1, 1'($urandom_range(0, 1)));
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
